// File: rtl/relay_pkg.sv
// Shared codes for the relay controller: state encoding, command/mode/status codes, timer width.
package relay_pkg;

    localparam int CNT_W = 21;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_MASTER_TX  = 2'd1,
        ST_SLAVE_RUN  = 2'd2,
        ST_DELAY_XFER = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_ABORT      = 2'b00,
        OP_MASTER     = 2'b01,
        OP_SLAVE      = 2'b10,
        OP_READ_DELAY = 2'b11
    } cmd_op_e;

    localparam logic [2:0] MOD_MASTER = 3'b000;
    localparam logic [2:0] MOD_SLAVE  = 3'b001;
    localparam logic [2:0] MOD_DELAY  = 3'b010;
    localparam logic [2:0] MOD_PARK   = 3'b111;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_TIMEOUT = 2'b01;
    localparam logic [1:0] STAT_ABORTED = 2'b10;

    function automatic logic [2:0] mod_of(input state_e s);
        logic [2:0] m;
        case (s)
            ST_MASTER_TX:  m = MOD_MASTER;
            ST_SLAVE_RUN:  m = MOD_SLAVE;
            ST_DELAY_XFER: m = MOD_DELAY;
            default:       m = MOD_PARK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/relay_ctrl_timer.sv
// Loadable 21-bit down-counter that saturates at zero and flags the zero value.
module relay_ctrl_timer
    import relay_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/relay_ctrl.sv
// Relay mode sequencer: MASTER/SLAVE/DELAY read-out control with result status.
// Define RELAY_CTRL_WATCHDOG_EN to time out MASTER_TX after TIMEOUT_CYCLES without a response.
//
// state         | meaning
// IDLE          | relay parked, waiting for a command
// MASTER_TX     | relay acting as master, waiting for peer response
// SLAVE_RUN     | relay acting as slave until aborted
// DELAY_XFER    | delay read-out, commands held off for DELAY_CYCLES
module relay_ctrl
    import relay_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1356000,
    parameter int unsigned DELAY_CYCLES   = 1048832
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    input  logic       rx_edge,
    output logic [2:0] mod_type,
    output logic       busy,
    output logic [1:0] status,
    output logic       status_valid
);

    // Load value is one less than the hold length: the zero cycle is the last one in the state.
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DELAY_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       mod_q;
    logic [1:0]       status_q, status_d;
    logic             sv_q, sv_d;
    logic             rdy_en_q;
    logic             accept;
    logic             abort_acc;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mod_q    <= MOD_PARK;
            status_q <= STAT_OK;
            sv_q     <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mod_q    <= mod_of(state_d);
            status_q <= status_d;
            sv_q     <= sv_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        sv_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op_e'(cmd_op))
                        OP_MASTER:     state_d = ST_MASTER_TX;
                        OP_SLAVE:      state_d = ST_SLAVE_RUN;
                        OP_READ_DELAY: state_d = ST_DELAY_XFER;
                        default:       state_d = ST_IDLE;
                    endcase
                end
            end
            ST_MASTER_TX: begin
                if (abort_acc) begin
                    state_d  = ST_IDLE;
                    status_d = STAT_ABORTED;
                    sv_d     = 1'b1;
                end else if (rx_edge) begin
                    state_d = ST_DELAY_XFER;
`ifdef RELAY_CTRL_WATCHDOG_EN
                end else if (tmr_zero) begin
                    state_d  = ST_IDLE;
                    status_d = STAT_TIMEOUT;
                    sv_d     = 1'b1;
`endif
                end
            end
            ST_SLAVE_RUN: begin
                if (abort_acc) begin
                    state_d  = ST_IDLE;
                    status_d = STAT_ABORTED;
                    sv_d     = 1'b1;
                end
            end
            ST_DELAY_XFER: begin
                if (tmr_zero) begin
                    state_d  = ST_IDLE;
                    status_d = STAT_OK;
                    sv_d     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = rdy_en_q && (state_q != ST_DELAY_XFER);
        busy         = (state_q != ST_IDLE);
        accept       = cmd_valid && cmd_ready;
        abort_acc    = accept && (cmd_op == OP_ABORT);
        tmr_load     = (state_d != state_q) && (state_d inside {ST_MASTER_TX, ST_DELAY_XFER});
        tmr_val      = (state_d == ST_DELAY_XFER) ? DLY_LOAD : TMO_LOAD;
        mod_type     = mod_q;
        status       = status_q;
        status_valid = sv_q;
    end

    relay_ctrl_timer u_timer (
        .clk_i      (ck_1356meg),
        .rst_n_i    (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

endmodule

// File: tb/tb_relay_ctrl.sv
// Randomized and directed bench for relay_ctrl against a mode/age reference model.
module tb_relay_ctrl;

    localparam int TMO = 53;
    localparam int DLY = 37;
`ifdef RELAY_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam logic [1:0] T_ABORT = 2'b00;
    localparam logic [1:0] T_MAST  = 2'b01;
    localparam logic [1:0] T_SLAV  = 2'b10;
    localparam logic [1:0] T_RDLY  = 2'b11;

    logic       ck = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       rx_edge;
    logic [2:0] mod_type;
    logic       busy;
    logic [1:0] status;
    logic       status_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] m_mod;
    int         m_age;
    logic [1:0] m_status;
    logic       m_pulse;
    logic       m_live;

    always #5 ck = ~ck;

    relay_ctrl #(.TIMEOUT_CYCLES(TMO), .DELAY_CYCLES(DLY)) dut (
        .ck_1356meg   (ck),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_ready    (cmd_ready),
        .rx_edge      (rx_edge),
        .mod_type     (mod_type),
        .busy         (busy),
        .status       (status),
        .status_valid (status_valid)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_outs();
        return {mod_type, busy, cmd_ready, status, status_valid};
    endfunction

    function automatic logic [7:0] m_outs();
        return {m_mod, (m_mod != 3'b111), (m_live && m_mod != 3'b010), m_status, m_pulse};
    endfunction

    task automatic model_reset();
        m_mod    = 3'b111;
        m_age    = 0;
        m_status = 2'b00;
        m_pulse  = 1'b0;
        m_live   = 1'b0;
    endtask

    // One clock of the reference: mode is the mod_type code, age counts cycles spent in it.
    task automatic model_step();
        logic       acc;
        logic [2:0] nxt;
        logic       fin;
        logic [1:0] res;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = cmd_valid && m_live && (m_mod != 3'b010);
        nxt = m_mod;
        fin = 1'b0;
        res = m_status;
        case (m_mod)
            3'b111: if (acc) begin
                if (cmd_op == T_MAST) nxt = 3'b000;
                else if (cmd_op == T_SLAV) nxt = 3'b001;
                else if (cmd_op == T_RDLY) nxt = 3'b010;
            end
            3'b000: begin
                if (acc && cmd_op == T_ABORT) begin
                    nxt = 3'b111; fin = 1'b1; res = 2'b10;
                end else if (rx_edge) begin
                    nxt = 3'b010;
                end else if (WD && m_age >= TMO) begin
                    nxt = 3'b111; fin = 1'b1; res = 2'b01;
                end
            end
            3'b001: if (acc && cmd_op == T_ABORT) begin
                nxt = 3'b111; fin = 1'b1; res = 2'b10;
            end
            default: if (m_age >= DLY) begin
                nxt = 3'b111; fin = 1'b1; res = 2'b00;
            end
        endcase
        m_pulse  = fin;
        m_status = res;
        m_age    = (nxt != m_mod) ? 1 : m_age + 1;
        m_mod    = nxt;
        m_live   = 1'b1;
    endtask

    always @(posedge ck) model_step();

    task automatic cyc(input logic v, input logic [1:0] op, input logic r);
        @(negedge ck);
        chk("cycle", {24'd0, dut_outs()}, {24'd0, m_outs()});
        cmd_valid = v;
        cmd_op    = op;
        rx_edge   = r;
        @(posedge ck);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 2'b00, 1'b0);
    endtask

    task automatic apply_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async", {24'd0, dut_outs()}, {24'd0, 3'b111, 1'b0, 1'b0, 2'b00, 1'b0});
        idle(2);
        @(negedge ck);
        rst_n = 1'b1;
        #1;
        chk("ready_before_clk", {31'd0, cmd_ready}, 32'd0);
    endtask

    initial begin
        int vp;
        int rp;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        rx_edge   = 1'b0;
        rst_n     = 1'b1;
        model_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mod", {29'd0, mod_type}, 32'd7);
        chk("rst_flags", {28'd0, busy, status, status_valid}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        idle(3);
        @(negedge ck);
        rst_n = 1'b1;
        #1;
        chk("ready_before_clk", {31'd0, cmd_ready}, 32'd0);
        idle(1);
        #1;
        chk("ready_after_clk", {31'd0, cmd_ready}, 32'd1);

        cyc(1'b0, 2'b00, 1'b1);
        #1 chk("rx_idle_ignored", {29'd0, mod_type}, 32'd7);

        // master exchange, response after 500 cycles, then delay read-out
        cyc(1'b1, T_MAST, 1'b0);
        #1 chk("m_enter", {29'd0, mod_type}, 32'd0);
        idle(499);
        cyc(1'b0, 2'b00, 1'b1);
        #1 chk("rx_to_delay", {29'd0, mod_type}, 32'd2);
        idle(DLY - 1);
        #1 chk("delay_hold", {28'd0, mod_type, status_valid}, {28'd0, 3'b010, 1'b0});
        idle(1);
        #1 chk("delay_done", {26'd0, mod_type, status, status_valid}, {26'd0, 3'b111, 2'b00, 1'b1});
        idle(1);
        #1 chk("pulse_one_cycle", {31'd0, status_valid}, 32'd0);

        // no response: watchdog expiry or indefinite wait
        cyc(1'b1, T_MAST, 1'b0);
        idle(TMO - 1);
        #1 chk("wd_pre", {29'd0, mod_type}, 32'd0);
        idle(1);
        #1 chk("wd_expiry", {26'd0, mod_type, status, status_valid},
               WD ? {26'd0, 3'b111, 2'b01, 1'b1} : {26'd0, 3'b000, 2'b00, 1'b0});
        idle(2 * TMO);
        #1 chk("wd_after", {29'd0, mod_type}, WD ? 32'd7 : 32'd0);
        cyc(1'b1, T_ABORT, 1'b0);
        idle(1);

        // slave ignores non-abort ops, abort ends it
        cyc(1'b1, T_SLAV, 1'b0);
        #1 chk("slave_enter", {29'd0, mod_type}, 32'd1);
        cyc(1'b1, T_MAST, 1'b0);
        #1 chk("slave_ignore_op", {29'd0, mod_type}, 32'd1);
        cyc(1'b0, 2'b00, 1'b1);
        cyc(1'b1, T_ABORT, 1'b0);
        #1 chk("slave_abort", {26'd0, mod_type, status, status_valid}, {26'd0, 3'b111, 2'b10, 1'b1});

        // priority: abort over rx, rx over timeout
        cyc(1'b1, T_MAST, 1'b0);
        idle(5);
        cyc(1'b1, T_ABORT, 1'b1);
        #1 chk("abort_beats_rx", {26'd0, mod_type, status, status_valid}, {26'd0, 3'b111, 2'b10, 1'b1});
        cyc(1'b1, T_MAST, 1'b0);
        idle(TMO - 1);
        cyc(1'b0, 2'b00, 1'b1);
        #1 chk("rx_beats_wd", {29'd0, mod_type}, 32'd2);
        idle(DLY);
        #1 chk("rx_wd_done", {26'd0, mod_type, status, status_valid}, {26'd0, 3'b111, 2'b00, 1'b1});

        // command held through a delay read-out
        cyc(1'b1, T_RDLY, 1'b0);
        #1 chk("rd_enter", {28'd0, mod_type, cmd_ready}, {28'd0, 3'b010, 1'b0});
        for (int k = 0; k < DLY - 1; k++) cyc(1'b1, T_MAST, 1'b0);
        #1 chk("rd_hold", {28'd0, mod_type, cmd_ready}, {28'd0, 3'b010, 1'b0});
        cyc(1'b1, T_MAST, 1'b0);
        #1 chk("rd_return", {27'd0, mod_type, cmd_ready, status_valid}, {27'd0, 3'b111, 1'b1, 1'b1});
        cyc(1'b1, T_MAST, 1'b0);
        #1 chk("rd_then_cmd", {29'd0, mod_type}, 32'd0);
        cyc(1'b1, T_ABORT, 1'b0);

        // reset in the middle of a delay read-out
        cyc(1'b1, T_RDLY, 1'b0);
        idle(10);
        apply_async_reset();
        idle(2);
        #1 chk("rst_no_pulse", {31'd0, status_valid}, 32'd0);

        vp = 6;
        rp = 12;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: vp = 3;
                    1: vp = 20;
                    default: vp = 80;
                endcase
                rp = ($urandom_range(0, 1) == 0) ? 8 : 100;
            end
            if ($urandom_range(0, 699) == 0) begin
                apply_async_reset();
            end else begin
                cyc(($urandom_range(0, vp - 1) == 0), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, rp - 1) == 0));
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
